// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: a single outstanding load/store over a
// valid/ready request channel, answered after LATENCY cycles on a valid/ready response channel.
module data_memory_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  we_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  access;
  logic                  in_range;
  logic                  mem_wr;
  logic [IDX_W-1:0]      idx;

  // Full-width compare so out-of-range addresses never alias onto low words.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (64'(a) < 64'(DEPTH));
  endfunction

  assign accept   = (state == ST_IDLE) && req_ready && req_valid;
  assign access   = (state == ST_WAIT) && (cnt == 4'd0);
  assign in_range = addr_in_range(addr_p0);
  assign idx      = IDX_W'(addr_p0);
  assign mem_wr   = reset && access && in_range && we_p0;

  // Stage p0: request captured at accept, held for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Array is not cleared by reset; a write only commits on the access edge.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx] <= wdata_p0;
    end
  end

  // Control FSM: IDLE accepts, WAIT counts down, RESP holds until consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_WAIT;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ~in_range;
            rsp_rdata <= (in_range && !we_p0) ? mem[idx] : '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= 4'd0;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: scoreboard of expected responses,
// plus a second instance built with LATENCY=1.
`timescale 1ns/1ps
module tb_data_memory_responder;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;

  logic          s_req_valid, s_req_ready, s_req_we;
  logic [AW-1:0] s_req_addr;
  logic [DW-1:0] s_req_wdata;
  logic          s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [DW-1:0] s_rsp_rdata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            total = 0;
  int            bad   = 0;
  int            acc_cyc;
  int            hs_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_t e;
    if (int'(addr) >= DEPTH) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else if (we) begin
      ref_mem[addr[9:0]] = wdata;
      e.rdata = '0;
      e.err   = 1'b0;
    end else begin
      e.rdata = ref_mem[addr[9:0]];
      e.err   = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input bit commit);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    if (commit) sb.push_back(model(we, addr, wdata));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic recv(input int lat);
    exp_t e;
    int   n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", 64'(rsp_valid), 64'd1);
    check("latency", 64'(cyc - acc_cyc), 64'(lat));
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rdata", 64'(rsp_rdata), 64'(e.rdata));
      check("err", 64'(rsp_err), 64'(e.err));
    end
    if (rsp_ready) begin
      @(negedge clk);
      check("rsp_clear", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    end
  endtask

  task automatic xact1(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       output logic [DW-1:0] rd, output logic er, output int lat);
    int n;
    int a;
    n = 0;
    s_req_valid = 1'b1;
    s_req_we    = we;
    s_req_addr  = addr;
    s_req_wdata = wd;
    while (s_req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 a = cyc;
    @(negedge clk);
    s_req_valid = 1'b0;
    n = 0;
    while (s_rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - a;
    rd  = s_rsp_rdata;
    er  = s_rsp_err;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic          any_valid;
    logic          do_acc, do_rsp;
    exp_t          e;
    int            accs [3];
    int            na, nr;
    logic [AW-1:0] t5_addr [3];
    logic [DW-1:0] rd1;
    logic          er1;
    int            lat1;

    reset       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b1;
    s_req_valid = 1'b0;
    s_req_we    = 1'b0;
    s_req_addr  = '0;
    s_req_wdata = '0;
    s_rsp_ready = 1'b1;

    // Test 1: reset, store then load address 5
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready), 64'd1);
    send(1'b1, 16'd5, 32'hDEADBEEF, 1'b1);
    recv(2);
    send(1'b0, 16'd5, '0, 1'b1);
    recv(2);
    send(1'b1, 16'd6, 32'h66666666, 1'b1);
    recv(2);
    send(1'b1, 16'd7, 32'h77777777, 1'b1);
    recv(2);
    send(1'b1, 16'd0, 32'h0BAD0000, 1'b1);
    recv(2);

    // Test 2: response stall with a pending request held on the input
    send(1'b0, 16'd5, '0, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'd6;
    recv(2);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_rdata", 64'(rsp_rdata), 64'h00000000DEADBEEF);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 hs_cyc = cyc;
    @(negedge clk);
    check("stall_rsp_clear", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    send(1'b0, 16'd6, '0, 1'b1);
    check("accept_after_hs", 64'(acc_cyc - hs_cyc), 64'd1);
    recv(2);

    // Test 3: out-of-range load/store, no aliasing onto word 0
    send(1'b0, 16'd1024, '0, 1'b1);
    recv(2);
    send(1'b1, 16'd1024, 32'h00001234, 1'b1);
    recv(2);
    send(1'b0, 16'd0, '0, 1'b1);
    recv(2);

    // Test 4: reset during WAIT discards a pending store
    send(1'b1, 16'd7, 32'hA5A5A5A5, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    reset = 1'b1;
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_valid = any_valid | rsp_valid;
    end
    check("midrst_no_rsp", 64'(any_valid), 64'd0);
    send(1'b0, 16'd7, '0, 1'b1);
    recv(2);

    // Test 5: back-to-back loads with valid/ready held high
    t5_addr[0] = 16'd5;
    t5_addr[1] = 16'd6;
    t5_addr[2] = 16'd7;
    na = 0;
    nr = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = t5_addr[0];
    for (int c = 0; c < 40 && nr < 3; c++) begin
      do_acc = req_valid && req_ready;
      do_rsp = rsp_valid && rsp_ready;
      if (do_rsp) begin
        e = sb.pop_front();
        check("b2b_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("b2b_err", 64'(rsp_err), 64'(e.err));
        nr++;
      end
      if (do_acc) begin
        sb.push_back(model(1'b0, req_addr, '0));
        accs[na] = cyc + 1;
        na++;
      end
      @(posedge clk);
      #1;
      if (do_acc) begin
        if (na < 3) req_addr = t5_addr[na];
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", 64'(na), 64'd3);
    check("b2b_responses", 64'(nr), 64'd3);
    check("b2b_gap01", 64'(accs[1] - accs[0]), 64'd4);
    check("b2b_gap12", 64'(accs[2] - accs[1]), 64'd4);

    // Test 6: LATENCY=1 instance
    xact1(1'b1, 16'd0, 32'hC0FFEE01, rd1, er1, lat1);
    check("l1_store_lat", 64'(lat1), 64'd1);
    check("l1_store_rsp", 64'({er1, rd1}), 64'd0);
    xact1(1'b0, 16'd0, '0, rd1, er1, lat1);
    check("l1_load_lat", 64'(lat1), 64'd1);
    check("l1_load_rdata", 64'(rd1), 64'h00000000C0FFEE01);
    check("l1_load_err", 64'(er1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
